// File: rtl/seg_serial_out.sv
// seg_serial_out: shifts a segment pattern MSB-first into an external shift register,
// then pulses the storage-register latch and reports completion.
`default_nettype none

module seg_serial_out #(
  parameter int DATA_BITS = 64,
  parameter int DIV_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] par_data,
  output logic                 busy,
  output logic                 done,
  output logic                 s_clk,
  output logic                 s_data,
  output logic                 s_latch,
  output logic                 s_clrn
);

  localparam int CNT_W = (DIV_BITS > 0) ? DIV_BITS : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     div_cnt;
  logic                 phase;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 clear_release;
  logic                 tick;
  logic                 last_bit;

  // With no divider every cycle is a tick, so s_clk toggles each clk.
  generate
    if (DIV_BITS == 0) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      assign tick = &div_cnt;
    end
  endgenerate

  assign last_bit = (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (tick && phase && last_bit) state_nxt = LATCH;
      LATCH:   if (tick) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      div_cnt       <= '0;
      phase         <= 1'b0;
      bit_cnt       <= '0;
      clear_release <= 1'b0;
    end else begin
      clear_release <= 1'b1;
      state         <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= par_data;
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          div_cnt <= div_cnt + CNT_W'(1);
          if (tick) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              // Data only changes on the falling half so it is stable around each rise.
              phase <= 1'b0;
              shreg <= shreg << 1;
              if (!last_bit) bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        LATCH: begin
          div_cnt <= div_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign s_clk   = phase;
  assign s_data  = (state == SHIFT) ? shreg[DATA_BITS-1] : 1'b0;
  assign s_latch = (state == LATCH);
  assign s_clrn  = clear_release;

endmodule

`default_nettype wire

// File: tb/tb_seg_serial_out.sv
// Randomized self-checking bench for seg_serial_out with default and zero divider settings.
`default_nettype none

module tb_seg_serial_out;

  logic        clk;
  logic        rst;
  logic        start,  start0;
  logic [63:0] par_data, par_data0;
  logic        busy, done, s_clk, s_data, s_latch, s_clrn;
  logic        busy0, done0, s_clk0, s_data0, s_latch0, s_clrn0;

  int checks   = 0;
  int failures = 0;

  seg_serial_out #(.DATA_BITS(64), .DIV_BITS(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .par_data(par_data),
    .busy(busy), .done(done), .s_clk(s_clk), .s_data(s_data),
    .s_latch(s_latch), .s_clrn(s_clrn)
  );

  seg_serial_out #(.DATA_BITS(64), .DIV_BITS(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .par_data(par_data0),
    .busy(busy0), .done(done0), .s_clk(s_clk0), .s_data(s_data0),
    .s_latch(s_latch0), .s_clrn(s_clrn0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: serial stream is the captured word MSB first; timing from the half-period rule.
  task automatic collect(input int which, input logic [63:0] d, input string tag,
                         input bit mutate, input logic [63:0] newd);
    int          div;
    int          exp_busy;
    int          cyc, edges, latch_cyc, done_cnt, done_at, unstable, no_toggle;
    logic [63:0] model;
    logic        prev_clk, prev_data, prev_latch;
    logic        b, sc, sd, sl, dn;
    div       = (which != 0) ? 0 : 2;
    exp_busy  = 64 * 2 * (1 << div) + (1 << div) + 1;
    cyc = 0; edges = 0; latch_cyc = 0; done_cnt = 0; done_at = 0; unstable = 0; no_toggle = 0;
    model = '0; prev_clk = 1'b0; prev_data = 1'b0; prev_latch = 1'b0;
    b = (which != 0) ? busy0 : busy;
    while (b && cyc < 2000) begin
      sc = (which != 0) ? s_clk0   : s_clk;
      sd = (which != 0) ? s_data0  : s_data;
      sl = (which != 0) ? s_latch0 : s_latch;
      dn = (which != 0) ? done0    : done;
      cyc++;
      if (sc && !prev_clk) begin
        edges++;
        model = {model[62:0], sd};
        if (sd !== prev_data) unstable++;
      end
      if (which != 0 && cyc > 1 && !sl && !dn && edges < 64 && sc == prev_clk) no_toggle++;
      if (prev_latch && !sl) check({tag, "_model_at_latch_fall"}, model, d);
      if (sl) latch_cyc++;
      if (dn) begin done_cnt++; done_at = cyc; end
      prev_clk = sc; prev_data = sd; prev_latch = sl;
      if (mutate && cyc == 100) par_data = newd;
      @(negedge clk);
      b = (which != 0) ? busy0 : busy;
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
    check({tag, "_sclk_edges"}, 64'(edges), 64'd64);
    check({tag, "_serial_word"}, model, d);
    check({tag, "_latch_cycles"}, 64'(latch_cyc), 64'(1 << div));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_last_cycle"}, 64'(done_at), 64'(exp_busy));
    check({tag, "_data_unstable"}, 64'(unstable), 64'd0);
    if (which != 0) check({tag, "_sclk_no_toggle"}, 64'(no_toggle), 64'd0);
  endtask

  task automatic send(input int which, input logic [63:0] d, input string tag);
    @(negedge clk);
    if (which != 0) begin par_data0 = d; start0 = 1'b1; end
    else begin par_data = d; start = 1'b1; end
    @(negedge clk);
    start = 1'b0; start0 = 1'b0;
    if (which != 0) par_data0 = {$urandom, $urandom};
    else par_data = {$urandom, $urandom};
    collect(which, d, tag, 1'b0, 64'd0);
  endtask

  initial begin
    logic [63:0] a, bdat;
    int          bad;
    clk = 1'b0; rst = 1'b1; start = 1'b0; start0 = 1'b0; par_data = '0; par_data0 = '0;
    #12;
    check("rst_outputs", {busy, done, s_clk, s_data, s_latch, s_clrn}, 6'd0);
    check("rst_outputs0", {busy0, done0, s_clk0, s_data0, s_latch0, s_clrn0}, 6'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("clrn_before_edge", s_clrn, 1'b0);
    @(negedge clk);
    check("clrn_after_edge", s_clrn, 1'b1);
    check("idle_busy", busy, 1'b0);

    send(0, 64'h8000_0000_0000_0001, "ends");
    send(0, 64'hA5A5_A5A5_A5A5_A5A5, "a5");
    for (int i = 0; i < 3; i++) send(0, {$urandom, $urandom}, "rand");

    // Start held high with input changing mid-transfer.
    a = {$urandom, $urandom}; bdat = ~a;
    @(negedge clk); par_data = a; start = 1'b1;
    @(negedge clk);
    collect(0, a, "hold1", 1'b1, bdat);
    check("idle_gap", busy, 1'b0);
    @(negedge clk);
    check("restart", busy, 1'b1);
    start = 1'b0;
    collect(0, bdat, "hold2", 1'b0, 64'd0);

    // Reset at cycle 200 of a transfer.
    @(negedge clk); par_data = {$urandom, $urandom}; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1; #1;
    check("abort_outputs", {busy, done, s_clk, s_data, s_latch, s_clrn}, 6'd0);
    bad = 0;
    repeat (3) begin @(negedge clk); if (s_latch || done) bad++; end
    rst = 1'b0;
    repeat (600) begin @(negedge clk); if (s_latch || done || busy) bad++; end
    check("abort_no_latch_done", 64'(bad), 64'd0);
    check("abort_clrn", s_clrn, 1'b1);

    send(1, 64'h8000_0000_0000_0001, "div0_ends");
    for (int i = 0; i < 2; i++) send(1, {$urandom, $urandom}, "div0_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_serial_out.md
SEG_SERIAL_OUT -- requirements
Module: seg_serial_out

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 64, giving the segment pattern width (8 digits x 8 segment bits).
REQ-002 The module SHALL have parameter DIV_BITS, default 2, so one serial half-period lasts 2^DIV_BITS clk cycles.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: load-and-send request, sampled only in IDLE.
REQ-006 The module SHALL have port par_data, input, DATA_BITS: the mapped segment pattern; bit DATA_BITS-1 is sent first.
REQ-007 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The module SHALL have port done, output, 1 bit: a one-cycle pulse on transfer completion.
REQ-009 The module SHALL have port s_clk, output, 1 bit: the serial shift clock to the external shift register.
REQ-010 The module SHALL have port s_data, output, 1 bit: the serial data, stable across each s_clk rising edge.
REQ-011 The module SHALL have port s_latch, output, 1 bit: the storage-register latch strobe, active high.
REQ-012 The module SHALL have port s_clrn, output, 1 bit: the shift-register clear, active low.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, LATCH, DONE, all registered.
REQ-014 In IDLE with start=1 at a clk edge, the block SHALL capture par_data into shreg, clear div_cnt, phase and bit_cnt, and enter SHIFT; busy rises after that same edge.
REQ-015 The block SHALL ignore start in every state other than IDLE; par_data changes after capture SHALL NOT affect the transfer.
REQ-016 div_cnt (DIV_BITS wide) SHALL increment every cycle in SHIFT and LATCH; a tick occurs when div_cnt is all ones, and div_cnt wraps to 0.
REQ-017 s_clk SHALL equal the phase register; phase SHALL be 0 in IDLE, LATCH and DONE.
REQ-018 s_data SHALL equal shreg[DATA_BITS-1] in SHIFT, and 0 otherwise.
REQ-019 On a SHIFT tick with phase=0, phase SHALL become 1, giving an s_clk rising edge with data stable for 2^DIV_BITS preceding cycles.
REQ-020 On a SHIFT tick with phase=1, phase SHALL become 0, shreg SHALL shift left one position filling 0, and bit_cnt SHALL increment.
REQ-021 The block SHALL enter LATCH when bit_cnt = DATA_BITS-1 on a phase=1 tick.
REQ-022 s_latch SHALL be 1 for exactly the 2^DIV_BITS cycles spent in LATCH; the next tick SHALL move the FSM to DONE.
REQ-023 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE.
REQ-024 With default parameters, busy SHALL stay high 517 cycles (512 SHIFT + 4 LATCH + 1 DONE) per transfer, producing exactly 64 s_clk rising edges.
REQ-025 bit_cnt width SHALL be clog2(DATA_BITS) and SHALL never wrap within a transfer.
REQ-026 start asserted on the cycle the FSM returns to IDLE SHALL be accepted on that edge; back-to-back transfers SHALL therefore be separated by one IDLE cycle.

Reset
REQ-027 While rst=1 the block SHALL immediately force state=IDLE, shreg=0, div_cnt=0, phase=0, bit_cnt=0, busy=0, done=0, s_clk=0, s_data=0, s_latch=0, and s_clrn=0.
REQ-028 s_clrn SHALL be 1 from the first clk edge after rst deasserts.
REQ-029 Reset asserted mid-transfer SHALL abort it without a latch pulse; no partial done SHALL be issued.

Verification
REQ-030 The bench SHALL run this case: rst pulse then release -> all outputs at REQ-027 values; s_clrn=1 after the first edge.
REQ-031 The bench SHALL run this case: par_data=64'h8000_0000_0000_0001 with a one-cycle start -> s_data high before s_clk edge 1 and edge 64, low at edges 2-63; busy 517 cycles; one done pulse.
REQ-032 The bench SHALL run this case: par_data=64'hA5A5_..._A5A5 captured in a 64-bit model on s_clk rises -> the model equals par_data when s_latch falls.
REQ-033 The bench SHALL run this case: start held high with par_data changed mid-transfer -> the first transfer is unaffected; the second starts one cycle after done.
REQ-034 The bench SHALL run this case: rst at cycle 200 of a transfer -> the outputs go idle at once; s_latch and done are never asserted.
REQ-035 The bench SHALL run this case: DIV_BITS=0 -> s_clk toggles every cycle; busy lasts 128+1+1 cycles.
